// File: rtl/gpu_pkg.sv
// gpu_pkg: shared definitions for the GPU rectangle loader.
//   RECT_WORDS    - words per rectangle record in CPU data memory
//   F_X..F_COLOR  - word offsets of each field inside a record
//   state_t       - loader FSM states
//   coll_entry_t  - layout of one collisions BRAM word, MSB first
package gpu_pkg;

  localparam int RECT_WORDS = 5;

  localparam int F_X     = 0;
  localparam int F_Y     = 1;
  localparam int F_W     = 2;
  localparam int F_H     = 3;
  localparam int F_COLOR = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] x2;
    logic [15:0] y2;
  } coll_entry_t;

endpackage

// File: rtl/sat_add16.sv
// sat_add16: 16-bit unsigned adder that clamps at 16'hFFFF instead of wrapping.
//   a, b : operands
//   y    : a + b, or 16'hFFFF on carry out
module sat_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic [16:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};
  assign y   = sum[16] ? 16'hFFFF : sum[15:0];

endmodule

// File: rtl/gpu_rect_loader.sv
// gpu_rect_loader: on each frame-load request, copies RECT_COUNT rectangle
// records (x, y, w, h, color) from CPU data memory into the GPU collisions
// and colors BRAMs. Each rectangle takes 6 cycles: 5 reads, 1 commit.
//   clk, rst_n           - clock, async active-low reset
//   start                - one-cycle load request (ignored unless idle)
//   mem_rd_addr/en/data  - CPU data-memory read port, 1-cycle read latency
//   coll_we/addr/din     - collisions BRAM write port ({x, y, x2, y2})
//   color_we/addr/din    - colors BRAM write port
//   busy                 - high during FETCH/COMMIT
//   done                 - one-cycle pulse when the last rectangle is written
module gpu_rect_loader
  import gpu_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR        = 16'h0000,
  parameter int          RECT_COUNT       = 64,
  parameter int          COLL_ADDR_WIDTH  = 10,
  parameter int          COLOR_ADDR_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [15:0]                 mem_rd_addr,
  output logic                        mem_rd_en,
  input  logic [15:0]                 mem_rd_data,
  output logic                        coll_we,
  output logic [COLL_ADDR_WIDTH-1:0]  coll_addr,
  output logic [63:0]                 coll_din,
  output logic                        color_we,
  output logic [COLOR_ADDR_WIDTH-1:0] color_addr,
  output logic [15:0]                 color_din,
  output logic                        busy,
  output logic                        done
);

  localparam int            IW   = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;
  localparam logic [IW-1:0] LAST = IW'(RECT_COUNT - 1);

  state_t             state, nxt;
  logic [2:0]         k;        // word index within the current record
  logic [IW-1:0]      ri;       // rectangle index
  logic [15:0]        base;     // address of word 0 of the current record
  logic [3:0][15:0]   fld;      // captured x, y, w, h
  logic [1:0]         cap_idx;
  logic [15:0]        x2, y2;
  coll_entry_t        ent;

  // Word k-1 is on mem_rd_data during FETCH cycle k.
  assign cap_idx = 2'(k - 3'd1);

  sat_add16 u_add_x (.a(fld[F_X]), .b(fld[F_W]), .y(x2));
  sat_add16 u_add_y (.a(fld[F_Y]), .b(fld[F_H]), .y(y2));

  assign ent = '{x: fld[F_X], y: fld[F_Y], x2: x2, y2: y2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k    <= '0;
      ri   <= '0;
      base <= '0;
      fld  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k    <= '0;
          ri   <= '0;
          base <= BASE_ADDR;
        end
        FETCH: begin
          if (k != 3'd0) fld[cap_idx] <= mem_rd_data;
          k <= (k == 3'(F_COLOR)) ? 3'd0 : k + 3'd1;
        end
        COMMIT: if (ri != LAST) begin
          ri   <= ri + IW'(1);
          base <= base + 16'(RECT_WORDS);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = FETCH;
      FETCH:   if (k == 3'(F_COLOR)) nxt = COMMIT;
      COMMIT:  nxt = (ri == LAST) ? DONE : FETCH;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from state and forced to zero outside their active
  // state, so reset (state IDLE, registers cleared) drives every output low.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    coll_we     = 1'b0;
    coll_addr   = '0;
    coll_din    = '0;
    color_we    = 1'b0;
    color_addr  = '0;
    color_din   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      FETCH: begin
        busy        = 1'b1;
        mem_rd_en   = 1'b1;
        mem_rd_addr = base + 16'(k);
      end
      COMMIT: begin
        busy       = 1'b1;
        coll_we    = 1'b1;
        color_we   = 1'b1;
        coll_addr  = COLL_ADDR_WIDTH'(ri);
        color_addr = COLOR_ADDR_WIDTH'(ri);
        coll_din   = ent;
        // color word is the read issued in the last FETCH cycle
        color_din  = mem_rd_data;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gpu_rect_loader.sv
// tb_gpu_rect_loader: directed bench. A 2-rectangle instance is driven from a
// table of hand-computed rectangle vectors; a default-size instance covers a
// full 64-rectangle frame.
module tb_gpu_rect_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:1023];

  // 2-rectangle instance
  logic        rst2_n, start2, d2_en, d2_cwe, d2_kwe, d2_busy, d2_done;
  logic [15:0] d2_addr, d2_data, d2_kdin;
  logic [9:0]  d2_caddr;
  logic [5:0]  d2_kaddr;
  logic [63:0] d2_cdin;

  // 64-rectangle instance
  logic        rst64_n, start64, d64_en, d64_cwe, d64_kwe, d64_busy, d64_done;
  logic [15:0] d64_addr, d64_data, d64_kdin;
  logic [9:0]  d64_caddr;
  logic [5:0]  d64_kaddr;
  logic [63:0] d64_cdin;

  always @(posedge clk) begin
    if (d2_en)  d2_data  <= mem[d2_addr[9:0]];
    if (d64_en) d64_data <= mem[d64_addr[9:0]];
  end

  gpu_rect_loader #(.BASE_ADDR(16'h0100), .RECT_COUNT(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2),
    .mem_rd_addr(d2_addr), .mem_rd_en(d2_en), .mem_rd_data(d2_data),
    .coll_we(d2_cwe), .coll_addr(d2_caddr), .coll_din(d2_cdin),
    .color_we(d2_kwe), .color_addr(d2_kaddr), .color_din(d2_kdin),
    .busy(d2_busy), .done(d2_done)
  );

  gpu_rect_loader #(.BASE_ADDR(16'h0200), .RECT_COUNT(64)) dut64 (
    .clk(clk), .rst_n(rst64_n), .start(start64),
    .mem_rd_addr(d64_addr), .mem_rd_en(d64_en), .mem_rd_data(d64_data),
    .coll_we(d64_cwe), .coll_addr(d64_caddr), .coll_din(d64_cdin),
    .color_we(d64_kwe), .color_addr(d64_kaddr), .color_din(d64_kdin),
    .busy(d64_busy), .done(d64_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] x, y, w, h, color;
    logic [63:0] exp_coll;
    logic [15:0] exp_color;
  } vec_t;

  vec_t vt [6];

  function automatic logic [95:0] outs2();
    return {d2_addr, d2_en, d2_cwe, d2_caddr, d2_cdin, d2_kwe, d2_kaddr, d2_kdin, d2_busy, d2_done};
  endfunction

  task automatic load_pair(input int j);
    for (int r = 0; r < 2; r++) begin
      mem[10'h100 + 10'(5*r) + 0] = vt[2*j+r].x;
      mem[10'h100 + 10'(5*r) + 1] = vt[2*j+r].y;
      mem[10'h100 + 10'(5*r) + 2] = vt[2*j+r].w;
      mem[10'h100 + 10'(5*r) + 3] = vt[2*j+r].h;
      mem[10'h100 + 10'(5*r) + 4] = vt[2*j+r].color;
    end
  endtask

  // One 2-rectangle load from table pair j; optionally re-pulse start mid-load.
  task automatic run2(input int j, input bit reassert);
    int t0, rel, nw, nbusy, ndone, done_rel, nrd;
    logic [9:0]  w_addr [4];
    logic [63:0] w_coll [4];
    logic [15:0] w_color [4];
    int          w_rel [4];
    nw = 0; nbusy = 0; ndone = 0; done_rel = -1; nrd = 0;
    load_pair(j);
    @(negedge clk);
    start2 = 1'b1;
    t0 = cyc;
    for (int s = 0; s < 24; s++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (d2_en) begin
        chk($sformatf("run%0d rd_addr%0d", j, nrd), d2_addr, 64'(16'h0100 + 16'(nrd)));
        nrd++;
      end
      if (d2_cwe || d2_kwe) begin
        chk($sformatf("run%0d we_pair", j), {d2_cwe, d2_kwe, 4'h0, d2_kaddr}, {2'b11, 4'h0, d2_caddr[5:0]});
        if (nw < 4) begin
          w_addr[nw] = d2_caddr; w_coll[nw] = d2_cdin; w_color[nw] = d2_kdin; w_rel[nw] = rel;
        end
        nw++;
      end
      if (d2_busy) nbusy++;
      if (d2_done) begin ndone++; done_rel = rel; end
      start2 = reassert && (rel == 3 || rel == 8);
    end
    start2 = 1'b0;
    chk($sformatf("run%0d n_reads", j), nrd, 10);
    chk($sformatf("run%0d n_writes", j), nw, 2);
    for (int r = 0; r < 2 && r < nw; r++) begin
      chk($sformatf("run%0d w%0d addr", j, r), w_addr[r], r);
      chk($sformatf("run%0d w%0d coll", j, r), w_coll[r], vt[2*j+r].exp_coll);
      chk($sformatf("run%0d w%0d color", j, r), w_color[r], vt[2*j+r].exp_color);
      chk($sformatf("run%0d w%0d cycle", j, r), w_rel[r], 6*(r+1));
    end
    chk($sformatf("run%0d done_cnt", j), ndone, 1);
    chk($sformatf("run%0d done_cycle", j), done_rel, 13);
    chk($sformatf("run%0d busy_cycles", j), nbusy, 12);
  endtask

  // Reset asserted during rectangle 1 fetch: load abandoned, block idles.
  task automatic run_reset();
    int t0, rel, nw, nw_after, nact;
    nw = 0; nw_after = 0; nact = 0;
    load_pair(0);
    @(negedge clk);
    start2 = 1'b1;
    t0 = cyc;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      rel = cyc - t0;
      start2 = 1'b0;
      if (d2_cwe) nw++;
    end
    chk("rst busy_before", d2_busy, 1);
    rst2_n = 1'b0;
    #1;
    chk("rst outs_zero_now", outs2(), 96'h0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("rst outs_zero_hold%0d", s), outs2(), 96'h0);
    end
    rst2_n = 1'b1;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      if (d2_cwe || d2_kwe) nw_after++;
      if (d2_busy || d2_en || d2_done) nact++;
    end
    chk("rst writes_before", nw, 1);
    chk("rst writes_after", nw_after, 0);
    chk("rst idle_after", nact, 0);
  endtask

  function automatic logic [15:0] sadd(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 17'h0FFFF) ? 16'hFFFF : s[15:0];
  endfunction

  task automatic run64();
    int t0, rel, nw, done_rel, ndone;
    logic [15:0] x, y, w, h;
    for (int i = 0; i < 64; i++) begin
      mem[10'h200 + 10'(5*i) + 0] = 16'(100 + 3*i);
      mem[10'h200 + 10'(5*i) + 1] = 16'(7*i);
      mem[10'h200 + 10'(5*i) + 2] = 16'(i);
      mem[10'h200 + 10'(5*i) + 3] = i[0] ? 16'hFFF0 : 16'(2*i);
      mem[10'h200 + 10'(5*i) + 4] = 16'(i * 16'h0111);
    end
    nw = 0; done_rel = -1; ndone = 0;
    @(negedge clk);
    start64 = 1'b1;
    t0 = cyc;
    for (int s = 0; s < 400; s++) begin
      @(negedge clk);
      rel = cyc - t0;
      start64 = 1'b0;
      if (d64_cwe) begin
        x = 16'(100 + 3*nw); y = 16'(7*nw); w = 16'(nw);
        h = nw[0] ? 16'hFFF0 : 16'(2*nw);
        chk($sformatf("f64 w%0d addr", nw), {d64_caddr, d64_kaddr}, {10'(nw), 6'(nw)});
        chk($sformatf("f64 w%0d coll", nw), d64_cdin, {x, y, sadd(x, w), sadd(y, h)});
        chk($sformatf("f64 w%0d color", nw), d64_kdin, 16'(nw * 16'h0111));
        chk($sformatf("f64 w%0d cycle", nw), rel, 6*(nw+1));
        nw++;
      end
      if (d64_done) begin ndone++; done_rel = rel; end
    end
    chk("f64 n_writes", nw, 64);
    chk("f64 done_cnt", ndone, 1);
    chk("f64 done_cycle", done_rel, 385);
  endtask

  initial begin
    vt[0] = '{16'd10,   16'd20,   16'd30,   16'd40,   16'hF800, 64'h000A_0014_0028_003C, 16'hF800};
    vt[1] = '{16'hFFF0, 16'h0005, 16'h0020, 16'h0000, 16'h07E0, 64'hFFF0_0005_FFFF_0005, 16'h07E0};
    vt[2] = '{16'h1234, 16'hFF00, 16'h0100, 16'h00FF, 16'h001F, 64'h1234_FF00_1334_FFFF, 16'h001F};
    vt[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF};
    vt[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 64'h0000_0000_0000_0000, 16'h0000};
    vt[5] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'hABCD, 64'h8000_7FFF_FFFF_FFFF, 16'hABCD};

    rst2_n = 1'b0; rst64_n = 1'b0; start2 = 1'b0; start64 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outs dut2", outs2(), 96'h0);
    chk("reset outs dut64", {d64_addr, d64_en, d64_cwe, d64_caddr, d64_kwe, d64_kaddr, d64_kdin, d64_busy, d64_done}, 64'h0);
    chk("reset coll_din dut64", d64_cdin, 64'h0);
    rst2_n = 1'b1; rst64_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle no_busy", {d2_busy, d64_busy, d2_en, d64_en}, 4'h0);

    run2(0, 1'b0);
    run2(1, 1'b1);
    run_reset();
    run2(2, 1'b0);
    run64();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpu_rect_loader.md
GPU_RECT_LOADER -- requirements
Module: gpu_rect_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'h0000: CPU data-memory word address of rectangle 0.
REQ-002 The block SHALL have parameter RECT_COUNT, default 64: number of rectangles loaded per frame.
REQ-003 The block SHALL have parameter COLL_ADDR_WIDTH, default 10: collisions BRAM address width.
REQ-004 The block SHALL have parameter COLOR_ADDR_WIDTH, default 6: colors BRAM address width.
REQ-005 The block SHALL have port clk  in  1  single clock, all logic on posedge.
REQ-006 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port start  in  1  one-cycle frame-load request (vsync).
REQ-008 The block SHALL have port mem_rd_addr  out  16  CPU data-memory read address.
REQ-009 The block SHALL have port mem_rd_en  out  1  read strobe; data returns next cycle.
REQ-010 The block SHALL have port mem_rd_data  in  16  read data, valid one cycle after mem_rd_en.
REQ-011 The block SHALL have port coll_we  out  1  collisions BRAM write enable.
REQ-012 The block SHALL have port coll_addr  out  COLL_ADDR_WIDTH  collisions BRAM write address.
REQ-013 The block SHALL have port coll_din  out  64  collisions BRAM write data.
REQ-014 The block SHALL have port color_we  out  1  colors BRAM write enable.
REQ-015 The block SHALL have port color_addr  out  COLOR_ADDR_WIDTH  colors BRAM write address.
REQ-016 The block SHALL have port color_din  out  16  colors BRAM write data.
REQ-017 The block SHALL have port busy  out  1  high while a load is in progress.
REQ-018 The block SHALL have port done  out  1  one-cycle pulse when a load completes.

Function
REQ-019 Rectangle i SHALL occupy 5 words at BASE_ADDR+5*i: x, y, w, h, color.
REQ-020 FSM states SHALL be IDLE, FETCH, COMMIT, DONE; reset state IDLE.
REQ-021 IDLE->FETCH on start=1, with rect index 0 and word index 0; busy rises in the first FETCH cycle.
REQ-022 In FETCH, cycles k=0..4 SHALL drive mem_rd_en=1 and mem_rd_addr=BASE_ADDR+5*i+k; the word returned in cycle k+1 is registered into field k.
REQ-023 FETCH->COMMIT after k=4 issues; in COMMIT, mem_rd_en=0 and the color word arrives on mem_rd_data.
REQ-024 In COMMIT, coll_we and color_we SHALL both be 1 for exactly one cycle, with coll_addr=color_addr=i.
REQ-025 coll_din SHALL be {x[15:0], y[15:0], x2[15:0], y2[15:0]}, MSB first.
REQ-026 x2=x+w and y2=y+h SHALL saturate at 16'hFFFF and never wrap.
REQ-027 color_din SHALL be mem_rd_data taken directly in COMMIT, not registered.
REQ-028 COMMIT->FETCH with i+1 if i<RECT_COUNT-1; otherwise COMMIT->DONE; each rectangle takes exactly 6 cycles.
REQ-029 In DONE, done=1 and busy=0 for one cycle, then DONE->IDLE.
REQ-030 start while busy=1 or in DONE SHALL be ignored; there is no queueing.
REQ-031 Write enables SHALL never be high outside COMMIT; write addresses and data are don't-care when enables are low.

Reset
REQ-032 When rst_n=0, all outputs SHALL be 0 (mem_rd_en, coll_we, color_we, busy, done, addresses, data), state IDLE, counters 0, regardless of clock.
REQ-033 Reset mid-load SHALL abandon the load with no further writes; BRAM contents already written are left as is.
REQ-034 After reset release, the block SHALL wait in IDLE for a new start.

Structure
REQ-035 Shared package gpu_pkg SHALL hold RECT_WORDS=5, field indices X/Y/W/H/COLOR, and the FSM state enum.
REQ-036 One sub-module, sat_add16 (16-bit saturating adder), SHALL be instantiated twice, for x2 and y2.
REQ-037 BRAM ports SHALL connect directly to the 1W1R sync GPU BRAMs: collisions 64-bit, colors 16-bit.

Verification
REQ-038 RECT_COUNT=2, BASE_ADDR=0x100, memory {10,20,30,40,0xF800,...}, start pulse -> addresses 0x100..0x104, coll_din=0x000A_0014_0028_003C, color_din=0xF800, addr 0, 6 cycles after start.
REQ-039 Same run -> second write at addr 1, done pulse 13 cycles after start, busy high 12 cycles.
REQ-040 x=0xFFF0, w=0x0020, y=5, h=0 -> x2=0xFFFF, y2=0x0005.
REQ-041 start reasserted in cycles 3 and 8 of a load -> ignored; write count and timing unchanged.
REQ-042 rst_n low in cycle 4 of rectangle 1 -> outputs 0 immediately, no COMMIT write, idle until next start.
REQ-043 Full RECT_COUNT=64 load -> 64 writes at addresses 0..63 with matching data, done at cycle 385.
